// File: rtl/fetch_if.sv
// Fetch-stage bus: redirect input, instruction-memory port and the IF/ID
// valid/ready output. The master modport is the fetch stage; slave is its environment.
interface fetch_if;
  logic        redirect_valid;
  logic [63:0] redirect_target;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
  logic [63:0] out_pc_plus4;

  modport master (
    input  redirect_valid, redirect_target,
    output imem_addr,
    input  imem_instr,
    output out_valid, out_instr,
    output out_pc, out_pc_plus4,
    input  out_ready
  );

  modport slave (
    output redirect_valid, redirect_target,
    input  imem_addr,
    output imem_instr,
    input  out_valid, out_instr,
    input  out_pc, out_pc_plus4,
    output out_ready
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, buffers {instr, pc} in a DEPTH-entry FIFO
// and hands the head to IF/ID. Ports: clk, reset (sync, high), bus (fetch_if.master).
module fetch_stage #(
  parameter logic [63:0] RESET_PC = 64'd0,
  parameter int          DEPTH    = 2
) (
  input  logic      clk,
  input  logic      reset,
  fetch_if.master   bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [63:0]   pc_q, pc_d;
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   instr_q [DEPTH];
  logic [31:0]   instr_d [DEPTH];
  logic [63:0]   epc_q [DEPTH];
  logic [63:0]   epc_d [DEPTH];

  logic valid;
  logic full;
  logic deq;
  logic enq;

  assign valid = (count_q != '0);
  assign full  = (count_q == CW'(DEPTH));
  assign deq   = valid & bus.out_ready;
  assign enq   = !bus.redirect_valid & (!full | deq);

  always_comb begin
    pc_d    = pc_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    instr_d = instr_q;
    epc_d   = epc_q;
    if (bus.redirect_valid) begin
      // Flush drops everything, including this cycle's dequeue.
      pc_d    = {bus.redirect_target[63:2], 2'b00};
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq) begin
        instr_d[tail_q] = bus.imem_instr;
        epc_d[tail_q]   = pc_q;
        tail_d          = tail_q + AW'(1);
        pc_d            = pc_q + 64'd4;
      end
      if (deq) begin
        head_d = head_q + AW'(1);
      end
      unique case (1'b1)
        enq && !deq: count_d = count_q + CW'(1);
        !enq && deq: count_d = count_q - CW'(1);
        default:     count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      pc_q    <= pc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: outputs are gated by the registered count.
  always_ff @(posedge clk) begin
    instr_q <= instr_d;
    epc_q   <= epc_d;
  end

  assign bus.imem_addr    = pc_q;
  assign bus.out_valid    = valid;
  assign bus.out_instr    = valid ? instr_q[head_q] : 32'd0;
  assign bus.out_pc       = valid ? epc_q[head_q] : 64'd0;
  assign bus.out_pc_plus4 = valid ? epc_q[head_q] + 64'd4 : 64'd0;

endmodule
